// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_queue: fetch-PC owner and in-order instruction queue to decode|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module inst_fetch_queue #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [DATA_W-1:0]          rom_data,
   input  logic                       redirect_valid,
   input  logic [ADDR_W-1:0]          redirect_addr,
   input  logic                       halt,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_inst,
   output logic [ADDR_W-1:0]          out_pc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] inst_q [DEPTH];
   logic [DATA_W-1:0] inst_d [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [ADDR_W-1:0] pc_d   [DEPTH];

   logic w_pop;
   logic w_push;

   assign w_pop  = out_valid & out_ready;
   assign w_push = ~redirect_valid & ~halt & ((count_q < C_DEPTH) | w_pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      inst_d     = inst_q;
      pc_d       = pc_q;
      if (redirect_valid) begin
         // The head offered this cycle is discarded, so pop is not honoured.
         fetch_pc_d = redirect_addr;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (w_push) begin
            inst_d[wr_ptr_q] = rom_data;
            pc_d[wr_ptr_q]   = fetch_pc_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            fetch_pc_d       = fetch_pc_q + ADDR_W'(1);
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= C_RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: every read is qualified by a nonzero count.
   always_ff @(posedge clk) begin
      inst_q <= inst_d;
      pc_q   <= pc_d;
   end

   assign rom_addr  = fetch_pc_q;
   assign count     = count_q;
   assign out_valid = (count_q != '0);
   assign out_inst  = out_valid ? inst_q[rd_ptr_q] : '0;
   assign out_pc    = out_valid ? pc_q[rd_ptr_q]   : '0;

endmodule
`default_nettype wire
